// File: rtl/renamed_reg_file_mp.sv
// renamed_reg_file_mp: multi-port architectural register file with a
// rename-status table. Each issued source comes back either as a ready value
// or as the ROB tag it is waiting on. Register x0 always reads as value 0, tag 0.
// Optional build macro RF_PENDING_CNT_EN adds a registered count of the
// renamed registers (pending_cnt).
module renamed_reg_file_mp #(
   parameter int REG_NUM  = 32,
   parameter int XLEN     = 32,
   parameter int TAG_W    = 4,
   parameter int ISSUE_W  = 2,
   parameter int COMMIT_W = 2,
   localparam int RID_W   = $clog2(REG_NUM)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rdy,
   input  logic                        flush,
   input  logic [ISSUE_W-1:0]          issue_valid,
   input  logic [ISSUE_W*RID_W-1:0]    issue_rs1,
   input  logic [ISSUE_W*RID_W-1:0]    issue_rs2,
   input  logic [ISSUE_W*RID_W-1:0]    issue_rd,
   input  logic [ISSUE_W*TAG_W-1:0]    issue_dest,
   output logic [ISSUE_W*XLEN-1:0]     vj,
   output logic [ISSUE_W*TAG_W-1:0]    qj,
   output logic [ISSUE_W*XLEN-1:0]     vk,
   output logic [ISSUE_W*TAG_W-1:0]    qk,
`ifdef RF_PENDING_CNT_EN
   output logic [RID_W:0]              pending_cnt,
`endif
   input  logic [COMMIT_W-1:0]         commit_valid,
   input  logic [COMMIT_W*RID_W-1:0]   commit_rd,
   input  logic [COMMIT_W*TAG_W-1:0]   commit_tag,
   input  logic [COMMIT_W*XLEN-1:0]    commit_value
);

   logic [XLEN-1:0]  values      [REG_NUM];
   logic [TAG_W-1:0] status      [REG_NUM];
   logic [XLEN-1:0]  values_nxt  [REG_NUM];
   logic [TAG_W-1:0] status_nxt  [REG_NUM];

   // Operand lookup for every slot/source against pre-edge state, with
   // intra-group rename bypass first and same-cycle commit forwarding second.
   always_comb begin
      logic [RID_W-1:0] r;
      logic [TAG_W-1:0] q;
      logic [XLEN-1:0]  v;
      logic             byp;
      logic [TAG_W-1:0] byp_tag;
      logic             cm;
      logic [XLEN-1:0]  cm_val;
      r       = '0;
      q       = '0;
      v       = '0;
      byp     = 1'b0;
      byp_tag = '0;
      cm      = 1'b0;
      cm_val  = '0;
      vj      = '0;
      qj      = '0;
      vk      = '0;
      qk      = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         for (int s = 0; s < 2; s++) begin
            r       = (s == 0) ? issue_rs1[i*RID_W +: RID_W] : issue_rs2[i*RID_W +: RID_W];
            q       = '0;
            v       = '0;
            byp     = 1'b0;
            byp_tag = '0;
            cm      = 1'b0;
            cm_val  = '0;
            if (r != '0) begin
               // later older slots overwrite earlier ones, so the youngest k < i wins
               for (int k = 0; k < i; k++) begin
                  if (issue_valid[k] && issue_rd[k*RID_W +: RID_W] == r) begin
                     byp     = 1'b1;
                     byp_tag = issue_dest[k*TAG_W +: TAG_W];
                  end
               end
               for (int j = 0; j < COMMIT_W; j++) begin
                  if (commit_valid[j] && commit_rd[j*RID_W +: RID_W] == r &&
                      commit_tag[j*TAG_W +: TAG_W] == status[r]) begin
                     cm     = 1'b1;
                     cm_val = commit_value[j*XLEN +: XLEN];
                  end
               end
               if (byp)
                  q = byp_tag;
               else if (cm)
                  v = cm_val;
               else if (status[r] != '0)
                  q = status[r];
               else
                  v = values[r];
            end
            if (s == 0) begin
               qj[i*TAG_W +: TAG_W] = q;
               vj[i*XLEN +: XLEN]   = v;
            end else begin
               qk[i*TAG_W +: TAG_W] = q;
               vk[i*XLEN +: XLEN]   = v;
            end
         end
      end
   end

   // Next state: commits, then renames (which override a same-cycle clear),
   // then flush wipes every rename regardless of rdy.
   always_comb begin
      logic [RID_W-1:0] crd;
      logic [RID_W-1:0] ird;
      crd        = '0;
      ird        = '0;
      values_nxt = values;
      status_nxt = status;
      if (rdy) begin
         for (int j = 0; j < COMMIT_W; j++) begin
            crd = commit_rd[j*RID_W +: RID_W];
            if (commit_valid[j] && crd != '0) begin
               values_nxt[crd] = commit_value[j*XLEN +: XLEN];
               if (status[crd] == commit_tag[j*TAG_W +: TAG_W])
                  status_nxt[crd] = '0;
            end
         end
      end
      if (rdy && !flush) begin
         for (int i = 0; i < ISSUE_W; i++) begin
            ird = issue_rd[i*RID_W +: RID_W];
            if (issue_valid[i] && ird != '0)
               status_nxt[ird] = issue_dest[i*TAG_W +: TAG_W];
         end
      end
      if (flush) begin
         for (int n = 0; n < REG_NUM; n++)
            status_nxt[n] = '0;
      end
      values_nxt[0] = '0;
      status_nxt[0] = '0;
   end

   // Storage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < REG_NUM; n++) begin
            values[n] <= '0;
            status[n] <= '0;
         end
      end else begin
         values <= values_nxt;
         status <= status_nxt;
      end
   end

`ifdef RF_PENDING_CNT_EN
   logic [RID_W:0] pending_nxt;

   // Popcount of renamed registers in the next state.
   always_comb begin
      pending_nxt = '0;
      for (int n = 1; n < REG_NUM; n++) begin
         if (status_nxt[n] != '0)
            pending_nxt = pending_nxt + (RID_W+1)'(1);
      end
   end

   // Registered pending count; it follows the next state so it holds with the table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending_cnt <= '0;
      else
         pending_cnt <= pending_nxt;
   end
`endif

endmodule

// File: tb/tb_renamed_reg_file_mp.sv
// Directed bench for renamed_reg_file_mp (default parameters).
module tb_renamed_reg_file_mp;
   localparam int ISSUE_W  = 2;
   localparam int COMMIT_W = 2;
   localparam int RID_W    = 5;
   localparam int TAG_W    = 4;
   localparam int XLEN     = 32;

   logic                       clk;
   logic                       rst_n;
   logic                       rdy;
   logic                       flush;
   logic [ISSUE_W-1:0]         issue_valid;
   logic [ISSUE_W*RID_W-1:0]   issue_rs1;
   logic [ISSUE_W*RID_W-1:0]   issue_rs2;
   logic [ISSUE_W*RID_W-1:0]   issue_rd;
   logic [ISSUE_W*TAG_W-1:0]   issue_dest;
   logic [ISSUE_W*XLEN-1:0]    vj;
   logic [ISSUE_W*TAG_W-1:0]   qj;
   logic [ISSUE_W*XLEN-1:0]    vk;
   logic [ISSUE_W*TAG_W-1:0]   qk;
   logic [COMMIT_W-1:0]        commit_valid;
   logic [COMMIT_W*RID_W-1:0]  commit_rd;
   logic [COMMIT_W*TAG_W-1:0]  commit_tag;
   logic [COMMIT_W*XLEN-1:0]   commit_value;
`ifdef RF_PENDING_CNT_EN
   logic [RID_W:0]             pending_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   renamed_reg_file_mp dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rdy          (rdy),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_rs1    (issue_rs1),
      .issue_rs2    (issue_rs2),
      .issue_rd     (issue_rd),
      .issue_dest   (issue_dest),
      .vj           (vj),
      .qj           (qj),
      .vk           (vk),
      .qk           (qk),
`ifdef RF_PENDING_CNT_EN
      .pending_cnt  (pending_cnt),
`endif
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_tag),
      .commit_value (commit_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_qj(input int s);
      return 32'(qj[s*TAG_W +: TAG_W]);
   endfunction
   function automatic logic [31:0] get_qk(input int s);
      return 32'(qk[s*TAG_W +: TAG_W]);
   endfunction
   function automatic logic [31:0] get_vj(input int s);
      return vj[s*XLEN +: XLEN];
   endfunction
   function automatic logic [31:0] get_vk(input int s);
      return vk[s*XLEN +: XLEN];
   endfunction

   task automatic clr;
      flush        = 1'b0;
      issue_valid  = '0;
      issue_rs1    = '0;
      issue_rs2    = '0;
      issue_rd     = '0;
      issue_dest   = '0;
      commit_valid = '0;
      commit_rd    = '0;
      commit_tag   = '0;
      commit_value = '0;
   endtask

   task automatic set_iss(input int s, input logic v, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] dest);
      issue_valid[s]               = v;
      issue_rs1[s*RID_W +: RID_W]  = rs1;
      issue_rs2[s*RID_W +: RID_W]  = rs2;
      issue_rd[s*RID_W +: RID_W]   = rd;
      issue_dest[s*TAG_W +: TAG_W] = dest;
   endtask

   task automatic set_cmt(input int p, input logic [4:0] rd, input logic [3:0] tag,
                          input logic [31:0] val);
      commit_valid[p]              = 1'b1;
      commit_rd[p*RID_W +: RID_W]  = rd;
      commit_tag[p*TAG_W +: TAG_W] = tag;
      commit_value[p*XLEN +: XLEN] = val;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      rdy   = 1'b1;
      clr();
      set_iss(0, 1'b0, 5'd5, 5'd0, 5'd0, 4'd0);
      #13;
      chk("rst_qj", get_qj(0), 0);
      chk("rst_vj", get_vj(0), 0);
      chk("rst_qk", get_qk(0), 0);
      chk("rst_vk", get_vk(0), 0);
`ifdef RF_PENDING_CNT_EN
      chk("rst_pcnt", 32'(pending_cnt), 0);
`endif
      rst_n = 1'b1;
      tick();

      // rename x3 -> 7, then async reset mid-cycle clears it
      clr(); set_iss(0, 1'b1, 5'd0, 5'd0, 5'd3, 4'd7);
      tick();
      clr(); set_iss(0, 1'b0, 5'd3, 5'd0, 5'd0, 4'd0);
      #1 chk("x3_renamed", get_qj(0), 7);
      rst_n = 1'b0;
      #1 chk("x3_async_rst", get_qj(0), 0);
      rst_n = 1'b1;
      tick();

      // intra-group bypass; slot 0 does not see its own rd
      clr();
      set_iss(0, 1'b1, 5'd4, 5'd0, 5'd4, 4'd3);
      set_iss(1, 1'b0, 5'd4, 5'd0, 5'd0, 4'd0);
      #1;
      chk("byp_s1_qj", get_qj(1), 3);
      chk("byp_s1_vj", get_vj(1), 0);
      chk("own_rd_s0_qj", get_qj(0), 0);
      tick();
      clr(); set_iss(0, 1'b0, 5'd4, 5'd0, 5'd0, 4'd0);
      #1 chk("x4_status", get_qj(0), 3);
`ifdef RF_PENDING_CNT_EN
      chk("pcnt_one", 32'(pending_cnt), 1);
`endif

      // commit forwarding on port 1, then retired state
      clr(); set_iss(0, 1'b1, 5'd0, 5'd0, 5'd6, 4'd2);
      tick();
      clr(); set_iss(0, 1'b0, 5'd0, 5'd6, 5'd0, 4'd0);
      #1 chk("x6_pending", get_qk(0), 2);
      set_cmt(1, 5'd6, 4'd2, 32'hDEADBEEF);
      #1;
      chk("fwd_qk", get_qk(0), 0);
      chk("fwd_vk", get_vk(0), 32'hDEADBEEF);
      tick();
      clr(); set_iss(0, 1'b0, 5'd0, 5'd6, 5'd0, 4'd0);
      #1;
      chk("x6_qk", get_qk(0), 0);
      chk("x6_vk", get_vk(0), 32'hDEADBEEF);

      // rename beats same-cycle commit clear of x8
      clr(); set_iss(0, 1'b1, 5'd0, 5'd0, 5'd8, 4'd5);
      tick();
      clr();
      set_cmt(0, 5'd8, 4'd5, 32'h1234);
      set_iss(0, 1'b0, 5'd0, 5'd8, 5'd0, 4'd0);
      set_iss(1, 1'b1, 5'd0, 5'd0, 5'd8, 4'd9);
      #1 chk("x8_fwd_vk", get_vk(0), 32'h1234);
      tick();
      clr(); set_iss(0, 1'b0, 5'd8, 5'd0, 5'd0, 4'd0);
      #1 chk("x8_renamed9", get_qj(0), 9);
      flush = 1'b1;
      tick();
      clr(); set_iss(0, 1'b0, 5'd8, 5'd0, 5'd0, 4'd0);
      #1;
      chk("x8_val_qj", get_qj(0), 0);
      chk("x8_val_vj", get_vj(0), 32'h1234);

      // stale commit: value written, status untouched
      clr(); set_iss(0, 1'b1, 5'd0, 5'd0, 5'd8, 4'd4);
      tick();
      clr(); set_cmt(0, 5'd8, 4'd5, 32'h55);
      tick();
      clr(); set_iss(0, 1'b0, 5'd8, 5'd0, 5'd0, 4'd0);
      #1 chk("stale_qj", get_qj(0), 4);
      flush = 1'b1;
      tick();
      clr(); set_iss(0, 1'b0, 5'd8, 5'd0, 5'd0, 4'd0);
      #1 chk("stale_vj", get_vj(0), 32'h55);

      // both ports write x10: port 1 wins; no forward when tag mismatches
      clr();
      set_cmt(0, 5'd10, 4'd1, 32'h11);
      set_cmt(1, 5'd10, 4'd1, 32'h22);
      set_iss(0, 1'b0, 5'd10, 5'd0, 5'd0, 4'd0);
      #1 chk("x10_nofwd", get_vj(0), 0);
      tick();
      clr(); set_iss(0, 1'b0, 5'd10, 5'd0, 5'd0, 4'd0);
      #1 chk("x10_port1", get_vj(0), 32'h22);

      // both ports matching x11: highest port forwards
      clr(); set_iss(0, 1'b1, 5'd0, 5'd0, 5'd11, 4'd6);
      tick();
      clr();
      set_cmt(0, 5'd11, 4'd6, 32'hA);
      set_cmt(1, 5'd11, 4'd6, 32'hB);
      set_iss(1, 1'b0, 5'd0, 5'd11, 5'd0, 4'd0);
      #1 chk("x11_fwd_hi", get_vk(1), 32'hB);
      tick();

      // x0 stays zero under rename and commit
      clr();
      set_iss(0, 1'b1, 5'd0, 5'd0, 5'd0, 4'd5);
      set_iss(1, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0);
      set_cmt(0, 5'd0, 4'd0, 32'hFF);
      #1 chk("x0_byp_qj", get_qj(1), 0);
      tick();
      clr(); set_iss(0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0);
      #1;
      chk("x0_qj", get_qj(0), 0);
      chk("x0_vj", get_vj(0), 0);

      // rdy=0 freezes rename and commit
      clr(); rdy = 1'b0;
      set_iss(0, 1'b1, 5'd0, 5'd0, 5'd12, 4'd3);
      set_cmt(0, 5'd12, 4'd0, 32'h77);
      tick();
      clr(); rdy = 1'b1; set_iss(0, 1'b0, 5'd12, 5'd0, 5'd0, 4'd0);
      #1;
      chk("hold_qj", get_qj(0), 0);
      chk("hold_vj", get_vj(0), 0);

      // flush with rdy=0 clears x1..x3 and drops rename of x7
      clr();
      set_iss(0, 1'b1, 5'd0, 5'd0, 5'd1, 4'd1);
      set_iss(1, 1'b1, 5'd0, 5'd0, 5'd2, 4'd2);
      tick();
      clr(); set_iss(0, 1'b1, 5'd0, 5'd0, 5'd3, 4'd3);
      tick();
      clr(); set_iss(0, 1'b0, 5'd3, 5'd0, 5'd0, 4'd0);
      #1 chk("x3_pre_flush", get_qj(0), 3);
      clr(); rdy = 1'b0; flush = 1'b1;
      set_iss(0, 1'b1, 5'd0, 5'd0, 5'd7, 4'd6);
      set_iss(1, 1'b0, 5'd7, 5'd0, 5'd0, 4'd0);
      #1 chk("flush_byp_qj", get_qj(1), 6);
      tick();
      clr(); rdy = 1'b1;
      set_iss(0, 1'b0, 5'd1, 5'd2, 5'd0, 4'd0);
      set_iss(1, 1'b0, 5'd3, 5'd7, 5'd0, 4'd0);
      #1;
      chk("flush_x1", get_qj(0), 0);
      chk("flush_x2", get_qk(0), 0);
      chk("flush_x3", get_qj(1), 0);
      chk("flush_x7", get_qk(1), 0);
`ifdef RF_PENDING_CNT_EN
      chk("flush_pcnt", 32'(pending_cnt), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
